// File: rtl/i2c_pkg.sv
// Shared types and widths for the receive-only I2C slave.
package i2c_pkg;

  localparam int I2C_ADDR_W = 7;
  localparam int I2C_BYTE_W = 8;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ADDR     = 3'd1,
    ACK_ADDR = 3'd2,
    DATA     = 3'd3,
    ACK_DATA = 3'd4,
    IGNORE   = 3'd5
  } i2c_state_e;

endpackage

// File: rtl/i2c_sro_if.sv
// Downstream side of the slave: received byte, its valid pulse, FSM debug state.
// Handshake: READ is a one-CLK strobe meaning "EXTMEM holds a new byte"; there
// is no ready, the consumer must take the byte in the strobe cycle. EXTMEM
// stays stable until the next strobe.
interface i2c_sro_if import i2c_pkg::*; ();
  logic [0:I2C_BYTE_W-1] EXTMEM;
  logic                  READ;
  i2c_state_e            dbg_state;

  modport slave  (output EXTMEM, READ, dbg_state);
  modport master (input  EXTMEM, READ, dbg_state);
endinterface

// File: rtl/i2c_sync_edge.sv
// 2-FF synchronizer with registered rise/fall detect. level_o, rise_o and
// fall_o all update on the same edge, so SCL and SDA chains stay aligned.
module i2c_sync_edge (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic ff1_q, ff2_q, prev_q, rise_q, fall_q;

  // Reset to the idle-bus level (high) so leaving reset never fakes a START.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ff1_q  <= 1'b1;
      ff2_q  <= 1'b1;
      prev_q <= 1'b1;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      ff1_q  <= d_i;
      ff2_q  <= ff1_q;
      prev_q <= ff2_q;
      rise_q <= ff2_q & ~prev_q;
      fall_q <= ~ff2_q & prev_q;
    end
  end

  assign level_o = prev_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/i2c_sro.sv
// Receive-only I2C slave: ACKs write transfers to SLAVE_ADDR and hands each
// data byte to the analyzer on EXTMEM with a one-CLK READ strobe.
module i2c_sro import i2c_pkg::*; #(
  parameter logic [I2C_ADDR_W-1:0] SLAVE_ADDR = 7'h3A
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       SCL,
  inout  wire        SDA,
  i2c_sro_if.slave   ext
);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  i2c_sync_edge u_scl (
    .clk_i(CLK), .rst_ni(RST_N), .d_i(SCL),
    .level_o(scl_lvl), .rise_o(scl_rise), .fall_o(scl_fall)
  );

  i2c_sync_edge u_sda (
    .clk_i(CLK), .rst_ni(RST_N), .d_i(SDA),
    .level_o(sda_lvl), .rise_o(sda_rise), .fall_o(sda_fall)
  );

  i2c_state_e            state_q, state_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [I2C_BYTE_W-1:0] sr_q, sr_d;
  logic [I2C_BYTE_W-1:0] extmem_q, extmem_d;
  logic                  read_q, read_d;
  logic                  sda_low_q, sda_low_d;

  logic                  start_cond, stop_cond;
  logic [I2C_BYTE_W-1:0] byte_in;

  assign start_cond = sda_fall & scl_lvl;
  assign stop_cond  = sda_rise & scl_lvl;
  assign byte_in    = {sr_q[I2C_BYTE_W-2:0], sda_lvl};

  // State and datapath registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      sr_q      <= '0;
      extmem_q  <= '0;
      read_q    <= 1'b0;
      sda_low_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sr_q      <= sr_d;
      extmem_q  <= extmem_d;
      read_q    <= read_d;
      sda_low_q <= sda_low_d;
    end
  end

  // Next state: START/STOP win over everything, otherwise walk the byte/ACK cycle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sr_d      = sr_q;
    extmem_d  = extmem_q;
    read_d    = 1'b0;
    sda_low_d = sda_low_q;

    if (start_cond) begin
      state_d   = ADDR;
      cnt_d     = '0;
      sda_low_d = 1'b0;
    end else if (stop_cond) begin
      state_d   = IDLE;
      sda_low_d = 1'b0;
    end else begin
      unique case (state_q)
        ADDR: begin
          if (scl_rise) begin
            sr_d  = byte_in;
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              if (byte_in[I2C_BYTE_W-1:1] == SLAVE_ADDR && !byte_in[0])
                state_d = ACK_ADDR;
              else
                state_d = IGNORE;
            end
          end
        end
        DATA: begin
          if (scl_rise) begin
            sr_d  = byte_in;
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              extmem_d = byte_in;
              read_d   = 1'b1;
              state_d  = ACK_DATA;
            end
          end
        end
        // First SCL fall (end of bit 8) pulls SDA, the next one (end of bit 9) releases it.
        ACK_ADDR, ACK_DATA: begin
          if (scl_fall) begin
            if (!sda_low_q) begin
              sda_low_d = 1'b1;
            end else begin
              sda_low_d = 1'b0;
              state_d   = DATA;
              cnt_d     = '0;
            end
          end
        end
        default: begin
          sda_low_d = 1'b0;
        end
      endcase
    end
  end

  assign SDA           = sda_low_q ? 1'b0 : 1'bz;
  assign ext.EXTMEM    = extmem_q;
  assign ext.READ      = read_q;
  assign ext.dbg_state = state_q;

endmodule

// File: tb/tb_i2c_sro.sv
// Bench for i2c_sro: a bit-banged I2C master, a byte scoreboard and directed
// plus random transfers.
module tb_i2c_sro;
  import i2c_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic m_scl = 1'b1;
  logic m_sda = 1'b1;
  wire  sda_bus;
  pullup (sda_bus);
  assign sda_bus = m_sda ? 1'bz : 1'b0;

  i2c_sro_if ext_if ();

  i2c_sro #(.SLAVE_ADDR(7'h3A)) dut (
    .CLK  (clk),
    .RST_N(rst_n),
    .SCL  (m_scl),
    .SDA  (sda_bus),
    .ext  (ext_if.slave)
  );

  int total = 0;
  int bad = 0;
  int pulses = 0;
  logic [7:0] exp_q[$];
  logic prev_read = 1'b0;

  // ---------------- reference model ----------------
  function automatic logic addr_ok(input logic [7:0] b);
    // Write to 7'h3A: address in the upper seven bits, R/W=0 in bit 0.
    return (b == 8'(7'h3A * 2));
  endfunction

  // ---------------- check helpers ----------------
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst_n && ext_if.READ) begin
      pulses++;
      total++;
      assert (!prev_read) else begin
        bad++;
        $error("FAIL read_width observed=2+ cycles expected=1");
      end
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $error("FAIL unexpected_read observed=%h expected=none", ext_if.EXTMEM);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        total++;
        assert (ext_if.EXTMEM === e) else begin
          bad++;
          $error("FAIL extmem_byte observed=%h expected=%h", ext_if.EXTMEM, e);
        end
      end
    end
    prev_read = ext_if.READ;
  end

  // ---------------- driver tasks ----------------
  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; wait_clk(4);
    m_scl = 1'b1; wait_clk(4);
    m_sda = 1'b0; wait_clk(4);
    m_scl = 1'b0; wait_clk(4);
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; wait_clk(4);
    m_scl = 1'b1; wait_clk(4);
    m_sda = 1'b1; wait_clk(8);
  endtask

  task automatic send_bit(input logic b);
    m_sda = b;    wait_clk(4);
    m_scl = 1'b1; wait_clk(8);
    m_scl = 1'b0; wait_clk(4);
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) send_bit(b[i]);
  endtask

  // Eight data bits plus the ninth clock, checking the slave's ACK/NACK.
  task automatic send_byte(input logic [7:0] b, input logic exp_ack, input string tag);
    logic ack;
    send_bits(b, 8);
    m_sda = 1'b1; wait_clk(4);
    m_scl = 1'b1; wait_clk(4);
    ack = (sda_bus === 1'b0);
    wait_clk(4);
    m_scl = 1'b0; wait_clk(4);
    chk(tag, 8'(ack), 8'(exp_ack));
  endtask

  // Full write transfer; the model decides ACKs and expected bytes.
  task automatic write_xfer(input logic [7:0] addr_b, input logic [7:0] d [$]);
    logic ok;
    ok = addr_ok(addr_b);
    i2c_start();
    send_byte(addr_b, ok, "addr_ack");
    foreach (d[k]) begin
      if (ok) exp_q.push_back(d[k]);
      send_byte(d[k], ok, "data_ack");
    end
    i2c_stop();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int p0;
    logic [7:0] bytes [$];

    // Reset state
    wait_clk(5);
    chk("rst_extmem", ext_if.EXTMEM, 8'h00);
    chk("rst_read", 8'(ext_if.READ), 8'h00);
    chk("rst_sda", 8'(sda_bus), 8'h01);
    chk("rst_state", 8'(ext_if.dbg_state), 8'(IDLE));
    rst_n = 1'b1;
    wait_clk(10);

    // Address write + one data byte
    p0 = pulses;
    bytes = '{8'hA5};
    write_xfer(8'h74, bytes);
    chk("a5_extmem", ext_if.EXTMEM, 8'hA5);
    chk32("a5_pulses", pulses - p0, 1);
    chk("a5_state", 8'(ext_if.dbg_state), 8'(IDLE));

    // Six-byte record
    p0 = pulses;
    bytes = '{8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h06};
    write_xfer(8'h74, bytes);
    chk32("rec_pulses", pulses - p0, 6);
    chk("rec_extmem", ext_if.EXTMEM, 8'h06);

    // Read request / wrong address
    p0 = pulses;
    bytes = '{8'h11, 8'h22};
    write_xfer(8'h76, bytes);
    write_xfer(8'h75, bytes);
    chk32("nack_pulses", pulses - p0, 0);
    chk("nack_extmem", ext_if.EXTMEM, 8'h06);

    // Repeated START after a partial byte
    p0 = pulses;
    i2c_start();
    send_byte(8'h74, 1'b1, "rs_addr1");
    send_bits(8'hF0, 4);
    i2c_start();
    send_byte(8'h74, 1'b1, "rs_addr2");
    exp_q.push_back(8'h5C);
    send_byte(8'h5C, 1'b1, "rs_data");
    i2c_stop();
    chk32("rs_pulses", pulses - p0, 1);
    chk("rs_extmem", ext_if.EXTMEM, 8'h5C);

    // STOP mid-byte
    p0 = pulses;
    i2c_start();
    send_byte(8'h74, 1'b1, "sm_addr");
    send_bits(8'h0F, 5);
    i2c_stop();
    chk32("sm_pulses", pulses - p0, 0);
    chk("sm_state", 8'(ext_if.dbg_state), 8'(IDLE));
    chk("sm_extmem", ext_if.EXTMEM, 8'h5C);
    bytes = '{8'hFF};
    write_xfer(8'h74, bytes);
    chk("ff_extmem", ext_if.EXTMEM, 8'hFF);

    // Reset mid-byte, then bytes without START are ignored
    p0 = pulses;
    i2c_start();
    send_byte(8'h74, 1'b1, "rm_addr");
    send_bits(8'h3C, 3);
    rst_n = 1'b0;
    wait_clk(2);
    chk("rm_extmem", ext_if.EXTMEM, 8'h00);
    chk("rm_read", 8'(ext_if.READ), 8'h00);
    chk("rm_sda", 8'(sda_bus), 8'h01);
    chk("rm_state", 8'(ext_if.dbg_state), 8'(IDLE));
    rst_n = 1'b1;
    wait_clk(4);
    send_bits(8'h1F, 5);
    send_byte(8'h3C, 1'b0, "rm_noack");
    send_byte(8'hC3, 1'b0, "rm_noack2");
    i2c_stop();
    chk32("rm_pulses", pulses - p0, 0);
    chk("rm_extmem2", ext_if.EXTMEM, 8'h00);

    // Random transfers against the model
    for (int t = 0; t < 8; t++) begin
      logic [7:0] a;
      int n;
      case ($urandom_range(0, 3))
        0, 1:    a = 8'h74;
        2:       a = 8'h75;
        default: a = 8'($urandom_range(0, 255));
      endcase
      n = $urandom_range(1, 4);
      bytes = {};
      for (int k = 0; k < n; k++) bytes.push_back(8'($urandom_range(0, 255)));
      p0 = pulses;
      write_xfer(a, bytes);
      chk32("rnd_pulses", pulses - p0, addr_ok(a) ? n : 0);
    end

    wait_clk(10);
    chk32("exp_q_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
